// File: rtl/tdm_pkg.sv
// Shared types and constants for the 4-channel TDM demultiplexer.
// Optional build macro: TDM_PARITY_EN adds a fifth (even parity) slot to
// every frame; without it a frame is exactly the four data slots.
package tdm_pkg;

    // Framer states: searching for a sync, or tracking frames.
    typedef enum logic [0:0] {
        HUNT = 1'b0,
        LOCK = 1'b1
    } state_t;

    // Number of data channels carried per frame.
    localparam int NCH = 4;

    // Slots per frame, including the parity slot when it is present.
`ifdef TDM_PARITY_EN
    localparam int NSLOT = 5;
`else
    localparam int NSLOT = 4;
`endif

    // Slot counter width and the index of the last slot in a frame.
    localparam int CNT_W = $clog2(NSLOT);
    localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(NSLOT - 1);

    // Miss counter width; large enough for the largest supported MISS_MAX.
    localparam int MISS_W = 3;

    // Even parity over a whole frame: a non-zero result flags a mismatch.
    function automatic logic frame_parity_err(input logic [NSLOT-1:0] frame);
        return ^frame;
    endfunction

endpackage

// File: rtl/tdm_slot_ctr.sv
// Slot position and missing-sync bookkeeping for tdm_demux4.
// cnt is the slot index expected in the current cycle (0 = frame boundary);
// miss counts consecutive frame boundaries that arrived without a sync.
// frame_done and sync_err are same-cycle events that the top registers.
// Optional build macro TDM_PARITY_EN changes the frame length via tdm_pkg.
module tdm_slot_ctr
    import tdm_pkg::*;
#(
    parameter int MISS_MAX = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sync,
    input  state_t            state,
    output logic [CNT_W-1:0]  cnt,
    output logic [MISS_W-1:0] miss,
    output logic              frame_done,
    output logic              sync_err
);

    localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(MISS_MAX - 1);

    logic in_lock;
    logic at_start;
    logic drop;

    // Classify the current cycle: frame completion, sync fault, loss of lock.
    always_comb begin
        in_lock    = (state == LOCK);
        at_start   = (cnt == '0);
        frame_done = in_lock && !sync && (cnt == LAST_SLOT);
        // A sync is a fault when it lands mid-frame, and its absence is a
        // fault at a frame boundary.
        sync_err   = in_lock && (sync != at_start);
        drop       = in_lock && !sync && at_start && (miss == MISS_LAST);
    end

    // Advance the slot position; any sync realigns the frame to slot 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            miss <= '0;
        end else if (sync) begin
            cnt  <= CNT_W'(1);
            miss <= '0;
        end else if (in_lock) begin
            if (at_start) begin
                if (drop) begin
                    // Lock is lost: stay at the boundary and wait in HUNT.
                    miss <= '0;
                end else begin
                    // Flywheel: assume the frame started on time anyway.
                    cnt  <= CNT_W'(1);
                    miss <= miss + MISS_W'(1);
                end
            end else if (cnt == LAST_SLOT) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/tdm_demux4.sv
// Serial TDM to 4-bit parallel demultiplexer with frame-sync tracking.
// One slot arrives per clock; sync marks slot 0. Completed frames are
// presented on dout with a one-cycle dout_valid strobe.
// Optional build macro: TDM_PARITY_EN adds an even parity slot and makes
// par_err live; otherwise par_err is tied low.
module tdm_demux4
    import tdm_pkg::*;
#(
    parameter int MISS_MAX = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           din,
    input  logic           sync,
    output logic [NCH-1:0] dout,
    output logic           dout_valid,
    output logic           locked,
    output logic           sync_err,
    output logic           par_err
);

    localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(MISS_MAX - 1);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [MISS_W-1:0]  miss;
    logic               frame_done;
    logic               slot_err;
    logic               drop;
    logic               store;
    logic [CNT_W-1:0]   slot_idx;
    logic [NSLOT-2:0]   shadow;
    logic [NSLOT-1:0]   frame_word;

    tdm_slot_ctr #(
        .MISS_MAX (MISS_MAX)
    ) u_slot_ctr (
        .clk        (clk),
        .rst        (rst),
        .sync       (sync),
        .state      (state),
        .cnt        (cnt),
        .miss       (miss),
        .frame_done (frame_done),
        .sync_err   (slot_err)
    );

    // Decide whether din is captured this cycle and which slot it fills.
    always_comb begin
        // A missing sync at a boundary with no flywheel budget left.
        drop       = slot_err && !sync && (miss == MISS_LAST);
        store      = (state == LOCK) ? !drop : sync;
        slot_idx   = sync ? '0 : cnt;
        // The last slot is taken straight from the line, never stored.
        frame_word = {din, shadow};
    end

    // Framer state: enter LOCK on a sync, fall back to HUNT on lost lock.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= HUNT;
        end else if ((state == HUNT) && sync) begin
            state <= LOCK;
        end else if (drop) begin
            state <= HUNT;
        end
    end

    // Collect all but the last slot of the frame in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow <= '0;
        end else begin
            for (int k = 0; k < NSLOT - 1; k++) begin
                if (store && (slot_idx == CNT_W'(k))) begin
                    shadow[k] <= din;
                end
            end
        end
    end

    // Publish a completed frame and register the status strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout       <= '0;
            dout_valid <= 1'b0;
            sync_err   <= 1'b0;
        end else begin
            dout_valid <= frame_done;
            sync_err   <= slot_err;
            if (frame_done) begin
                dout <= frame_word[NCH-1:0];
            end
        end
    end

    assign locked = (state == LOCK);

`ifdef TDM_PARITY_EN
    // Flag a parity mismatch alongside the frame it belongs to.
    always_ff @(posedge clk) begin
        if (rst) begin
            par_err <= 1'b0;
        end else begin
            par_err <= frame_done && frame_parity_err(frame_word);
        end
    end
`else
    assign par_err = 1'b0;
`endif

endmodule

// File: tb/tb_tdm_demux4.sv
// Scoreboard bench for tdm_demux4: directed frame scenarios followed by
// randomized line traffic, all checked against a frame-level model.
// Build with TDM_PARITY_EN defined to exercise the parity variant.
module tb_tdm_demux4;

`ifdef TDM_PARITY_EN
    localparam int NSLOT = 5;
`else
    localparam int NSLOT = 4;
`endif
    localparam int MISS_MAX = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       din;
    logic       sync;
    logic [3:0] dout;
    logic       dout_valid;
    logic       locked;
    logic       sync_err;
    logic       par_err;

    always #5 clk = ~clk;

    tdm_demux4 #(
        .MISS_MAX (MISS_MAX)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .sync       (sync),
        .dout       (dout),
        .dout_valid (dout_valid),
        .locked     (locked),
        .sync_err   (sync_err),
        .par_err    (par_err)
    );

    typedef struct {
        logic       lk;
        logic       se;
        logic       dv;
        logic       pe;
        logic [3:0] dq;
    } st_t;

    typedef struct {
        logic [3:0] dq;
        logic       pe;
    } fr_t;

    st_t stq[$];
    fr_t frq[$];

    int errors = 0;
    int checks = 0;

    // Reference model: lock flag, count of missed syncs, and the bits of
    // the frame collected so far (empty queue = at a frame boundary).
    bit         m_lock = 1'b0;
    int         m_miss = 0;
    bit         m_bits[$];
    logic [3:0] m_dout = 4'b0000;

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk4(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [4:0] fw(input logic [3:0] d);
        return {^d, d};
    endfunction

    // Drive one slot, update the model, and queue what the DUT must show
    // once this edge has been taken.
    task automatic tick(input logic s, input logic d, input logic r);
        st_t  e;
        fr_t  f;
        bit   done;
        logic p;
        logic [3:0] v;
        sync = s;
        din  = d;
        rst  = r;
        e.se = 1'b0;
        e.dv = 1'b0;
        e.pe = 1'b0;
        done = 1'b0;
        p    = 1'b0;
        v    = 4'b0000;
        if (r) begin
            m_lock = 1'b0;
            m_miss = 0;
            m_bits.delete();
            m_dout = 4'b0000;
        end else if (!m_lock) begin
            if (s) begin
                m_lock = 1'b1;
                m_miss = 0;
                m_bits.delete();
                m_bits.push_back(d);
            end
        end else if (s) begin
            e.se = (m_bits.size() != 0);
            m_bits.delete();
            m_bits.push_back(d);
            m_miss = 0;
        end else if (m_bits.size() == 0) begin
            e.se = 1'b1;
            if (m_miss == MISS_MAX - 1) begin
                m_lock = 1'b0;
                m_miss = 0;
            end else begin
                m_miss++;
                m_bits.push_back(d);
            end
        end else begin
            m_bits.push_back(d);
            if (m_bits.size() == NSLOT) begin
                done = 1'b1;
                for (int k = 0; k < 4; k++) v[k] = m_bits[k];
`ifdef TDM_PARITY_EN
                foreach (m_bits[k]) p = p ^ m_bits[k];
`endif
                m_dout = v;
                e.dv   = 1'b1;
                e.pe   = p;
                f.dq   = v;
                f.pe   = p;
                m_bits.delete();
            end
        end
        e.lk = m_lock;
        e.dq = m_dout;
        @(posedge clk);
        stq.push_back(e);
        if (done) frq.push_back(f);
        #1;
    endtask

    task automatic send_frame(input logic [4:0] w, input bit with_sync);
        for (int s = 0; s < NSLOT; s++) begin
            tick(with_sync && (s == 0), w[s], 1'b0);
        end
    endtask

    // Monitor: compare every cycle's status, and match each strobed frame
    // against the expected-frame queue.
    always @(negedge clk) begin
        st_t e;
        fr_t f;
        if (stq.size() > 0) begin
            e = stq.pop_front();
            chk1("locked", locked, e.lk);
            chk1("sync_err", sync_err, e.se);
            chk1("dout_valid", dout_valid, e.dv);
            chk1("par_err", par_err, e.pe);
            chk4("dout", dout, e.dq);
            if (dout_valid === 1'b1) begin
                if (frq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL frame_queue: dout_valid=1 but no frame expected at %0t", $time);
                end else begin
                    f = frq.pop_front();
                    chk4("frame_dout", dout, f.dq);
                    chk1("frame_par", par_err, f.pe);
                end
            end
        end
    end

    initial begin
        logic [4:0] w;
        logic s_r;
        logic d_r;
        logic r_r;
        int   g;
        rst  = 1'b1;
        sync = 1'b0;
        din  = 1'b0;

        repeat (3) tick(1'b0, 1'b0, 1'b1);
        chk1("reset_locked", locked, 1'b0);
        chk1("reset_valid", dout_valid, 1'b0);
        chk1("reset_sync_err", sync_err, 1'b0);
        chk1("reset_par_err", par_err, 1'b0);
        chk4("reset_dout", dout, 4'b0000);

        // Line activity without a sync is ignored while hunting.
        tick(1'b0, 1'b1, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        chk1("hunt_locked", locked, 1'b0);

        // First frame 1,0,1,1 from HUNT.
        w = fw(4'b1101);
        tick(1'b1, w[0], 1'b0);
        chk1("first_locked", locked, 1'b1);
        chk1("first_no_valid", dout_valid, 1'b0);
        for (int s = 1; s < NSLOT; s++) tick(1'b0, w[s], 1'b0);
        chk1("first_valid", dout_valid, 1'b1);
        chk4("first_dout", dout, 4'b1101);

        // Back-to-back frames.
        send_frame(fw(4'hA), 1'b1);
        chk4("b2b_dout_a", dout, 4'hA);
        send_frame(fw(4'h5), 1'b1);
        chk4("b2b_dout_5", dout, 4'h5);
        send_frame(fw(4'hF), 1'b1);
        chk4("b2b_dout_f", dout, 4'hF);
        chk1("b2b_valid", dout_valid, 1'b1);

        // Sync arriving at slot 2 restarts the frame.
        tick(1'b1, 1'b1, 1'b0);
        tick(1'b0, 1'b1, 1'b0);
        w = fw(4'h6);
        tick(1'b1, w[0], 1'b0);
        chk1("early_sync_err", sync_err, 1'b1);
        for (int s = 1; s < NSLOT; s++) tick(1'b0, w[s], 1'b0);
        chk4("early_realigned_dout", dout, 4'h6);

        // Two consecutive missing syncs: flywheel once, then lose lock.
        send_frame(fw(4'h9), 1'b1);
        send_frame(fw(4'h3), 1'b0);
        chk4("flywheel_dout", dout, 4'h3);
        w = fw(4'hC);
        tick(1'b0, w[0], 1'b0);
        chk1("miss2_sync_err", sync_err, 1'b1);
        chk1("miss2_unlocked", locked, 1'b0);
        for (int s = 1; s < NSLOT; s++) tick(1'b0, w[s], 1'b0);
        chk4("miss2_dout_hold", dout, 4'h3);

        // Reset in the middle of a frame.
        tick(1'b1, 1'b1, 1'b0);
        tick(1'b0, 1'b1, 1'b0);
        tick(1'b0, 1'b1, 1'b1);
        chk4("midrst_dout", dout, 4'b0000);
        chk1("midrst_locked", locked, 1'b0);
        for (int s = 0; s < NSLOT; s++) tick(1'b0, 1'b1, 1'b0);
        send_frame(fw(4'hE), 1'b1);
        chk4("midrst_next_dout", dout, 4'hE);

`ifdef TDM_PARITY_EN
        // Parity slot: 1,1,0,0 with parity 1 is odd overall.
        send_frame({1'b1, 4'b0011}, 1'b1);
        chk1("par_bad_flag", par_err, 1'b1);
        chk1("par_bad_valid", dout_valid, 1'b1);
        chk4("par_bad_dout", dout, 4'b0011);
        send_frame({1'b0, 4'b0011}, 1'b1);
        chk1("par_good_flag", par_err, 1'b0);
        chk4("par_good_dout", dout, 4'b0011);
`endif

        // Random traffic: mostly well-formed frames with stray, missing
        // and shifted syncs plus occasional resets.
        g = 0;
        repeat (3000) begin
            r_r = ($urandom_range(0, 299) == 0);
            if (g == 0) s_r = ($urandom_range(0, 11) != 0);
            else        s_r = ($urandom_range(0, 24) == 0);
            d_r = 1'($urandom_range(0, 1));
            tick(s_r, d_r, r_r);
            if ($urandom_range(0, 49) == 0) g = $urandom_range(0, NSLOT - 1);
            else                            g = (g + 1) % NSLOT;
        end

        sync = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (frq.size() != 0 || stq.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d frames and %0d cycles still expected", frq.size(), stq.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tdm_demux4.md
TDM_DEMUX4 -- requirements
Module: tdm_demux4

Interface
REQ-001 The block SHALL have parameter MISS_MAX, default 2: consecutive missing frame syncs that drop lock (legal range 1..7).
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port din, input, 1 bit: serial time-division line, one slot per clk cycle.
REQ-005 The block SHALL have port sync, input, 1 bit: frame marker, high in the cycle that carries slot 0.
REQ-006 The block SHALL have port dout, output, 4 bits: last complete frame; dout[k] = slot k.
REQ-007 The block SHALL have port dout_valid, output, 1 bit: one-cycle pulse when dout updates.
REQ-008 The block SHALL have port locked, output, 1 bit: high while the FSM is in LOCK.
REQ-009 The block SHALL have port sync_err, output, 1 bit: one-cycle pulse on a misplaced or missing sync.
REQ-010 The block SHALL have port par_err, output, 1 bit: one-cycle pulse, coincident with dout_valid, on a parity mismatch.

Function
REQ-011 The block SHALL implement FSM states HUNT and LOCK, a slot counter cnt (0..NSLOT-1) and a miss counter miss (0..MISS_MAX-1); NSLOT=4, or 5 per REQ-022.
REQ-012 In HUNT, sync=0 SHALL discard din; sync=1 SHALL store din as slot 0, set cnt=1 and miss=0, and enter LOCK.
REQ-013 In LOCK with cnt!=0 and sync=0, the block SHALL store din as slot cnt and increment cnt, wrapping NSLOT-1 -> 0.
REQ-014 When slot NSLOT-1 is stored at cycle t, the block SHALL load dout from the shadow slots and pulse dout_valid at cycle t+1; latency is the first bit plus NSLOT cycles.
REQ-015 In LOCK with cnt!=0 and sync=1, the block SHALL pulse sync_err, discard the partial frame (no dout_valid), store din as slot 0, set cnt=1 and miss=0.
REQ-016 In LOCK with cnt==0 and sync=1, the block SHALL store slot 0 and clear miss; back-to-back frames SHALL produce dout_valid every NSLOT cycles.
REQ-017 In LOCK with cnt==0 and sync=0, the block SHALL pulse sync_err; if miss==MISS_MAX-1 it SHALL enter HUNT and discard din, otherwise it SHALL increment miss and accept din as slot 0 (flywheel).
REQ-018 dout SHALL hold its value between dout_valid pulses and while in HUNT.
REQ-019 When dout_valid from frame completion coincides with a sync_err event in the same cycle, both pulses SHALL assert.

Reset
REQ-020 When rst=1 at a clk edge, the block SHALL set state=HUNT, cnt=0, miss=0, shadow=0, dout=4'b0000, dout_valid=0, locked=0, sync_err=0 and par_err=0, taking priority over all inputs.
REQ-021 A reset asserted mid-frame SHALL discard the partial frame, and no dout_valid SHALL follow it.

Configuration
REQ-022 When macro TDM_PARITY_EN is defined, the block SHALL set NSLOT=5, treat slot 4 as even parity over slots 0..3, and pulse par_err with dout_valid when ^{slots0..3, slot4} != 0; dout SHALL still update.
REQ-023 When TDM_PARITY_EN is undefined, the block SHALL set NSLOT=4, keep the par_err port, and drive par_err constant 0.

Structure
REQ-024 Package tdm_pkg SHALL hold the state enum (HUNT, LOCK), constant NCH=4, and NSLOT derived from TDM_PARITY_EN.
REQ-025 Slot counter and miss counter logic SHALL reside in one sub-module, tdm_slot_ctr (inputs: sync, state; outputs: cnt, miss, frame_done, sync_err); the data path and FSM SHALL stay in tdm_demux4.

Verification
REQ-026 The bench SHALL apply sync=1 with din 1,0,1,1 on consecutive cycles from HUNT and check dout=4'b1101 with a single dout_valid pulse on the 5th cycle and locked=1 from the 2nd cycle.
REQ-027 The bench SHALL send three back-to-back frames 0xA, 0x5, 0xF and check dout_valid every 4 cycles, dout in sequence, and sync_err=0 throughout.
REQ-028 The bench SHALL assert sync at slot 2 of a frame and check one sync_err pulse, no dout_valid for that frame, and the next frame decoded aligned to the new sync.
REQ-029 With MISS_MAX=2, the bench SHALL omit sync on two consecutive frames and check the first is decoded with sync_err, the second gives sync_err and locked=0 with no dout_valid, and dout holds its value.
REQ-030 The bench SHALL assert rst at slot 2 and check all outputs return to 0 on the next cycle, with no dout_valid until a new sync plus a full frame.
REQ-031 With TDM_PARITY_EN defined, the bench SHALL send data 1,1,0,0 with parity 1 and check dout=4'b0011 with par_err=1 coincident with dout_valid, and that parity 0 gives par_err=0.
